ddr_prbs_checker: RTL and testbench
===================================

# ddr_prbs_checker

Downstream consumer of the DDR input capture stage. Each `clk` cycle it takes the two bits that stage produces: the rising-edge sample and the falling-edge sample. It checks them against the 5-bit XNOR PRBS used by the team's DDR stimulus, `next = {s[3:0], ~(s[4]^s[2])}`. It reports lock status and a saturating bit-error count, which are routed to `uo_out` for on-silicon DDR margin testing.

## Interface
Parameters:
- `LOCK_COUNT`, 4: consecutive fully-matching cycles required to declare lock (2..15).
- `UNLOCK_COUNT`, 4: consecutive cycles with ≥1 bit error that drop lock (2..15).
- `ERR_W`, 8: error counter width.

Ports:
- `clk`  in  1  capture-stage clock; one bit pair per rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  pair valid this cycle; when low, all state holds.
- `bit_rise`  in  1  earlier bit of the pair (rising-edge sample).
- `bit_fall`  in  1  later bit of the pair (falling-edge sample).
- `clr_err`  in  1  synchronous clear of `err_cnt`.
- `locked`  out  1  high in LOCKED.
- `err_pulse`  out  1  one-cycle pulse per cycle containing ≥1 mismatch while LOCKED.
- `err_cnt`  out  ERR_W  saturating count of mismatched bits while LOCKED.
- `state`  out  2  SEARCH=0, VERIFY=1, LOCKED=2.

## Operation
- Shadow register `r[4:0]` holds the last 5 stream bits, oldest in `r[4]`.
- Predictions: `p0 = ~(r[4]^r[2])`, `p1 = ~(r[3]^r[1])`. Per-bit mismatch: `m0 = bit_rise^p0`, `m1 = bit_fall^p1`.
- SEARCH:
  - `r <= {r[2:0], bit_rise, bit_fall}`.
  - A fill counter counts valid cycles; after the 3rd valid cycle, go to VERIFY with match count 0.
- VERIFY:
  - `r` keeps loading from data.
  - A cycle is a match if `m0==0`, `m1==0` and `r != 5'b11111` (the XNOR lockup state never counts).
  - On a match, the match count increments; on the LOCK_COUNT-th consecutive match, go to LOCKED.
  - On a mismatch, the match count resets to 0 and the state stays VERIFY.
  - Errors are not counted in VERIFY.
- LOCKED:
  - `r <= {r[2:0], p0, p1}`, free-running, so a flipped data bit does not corrupt the predictions.
  - `err_cnt` advances by `m0+m1` (0..2), saturating at all-ones.
  - A bad-cycle counter increments on any mismatch and resets on a clean cycle.
  - On the UNLOCK_COUNT-th consecutive bad cycle, go to SEARCH with the fill count at 0; `err_cnt` is retained.
- `clr_err` wins over a same-cycle increment: `err_cnt <= 0`.
- Saturation: when the count is at all-ones, it holds; when one below all-ones and the increment is 2, it goes to all-ones.
- When `in_valid` is low: no state change, no counting, `err_pulse` low.

## Timing
- Reset values: `state`=SEARCH, `r`=0, all counters 0, `locked`=0, `err_pulse`=0, `err_cnt`=0.
- All outputs are registered; no combinational input-to-output path.
- `locked` rises on the edge that samples the LOCK_COUNT-th match. With the defaults and a clean stream, that is the 7th valid edge after reset release.
- `err_pulse` and the `err_cnt` update both appear on the edge that samples the erroneous pair (latency 1 cycle).
- `locked` falls on the edge that samples the UNLOCK_COUNT-th bad cycle.
- Asserting `rst_n` mid-operation immediately forces all reset values (asynchronous); the first valid cycle after release is fill cycle 1.

## Structure
- Package `ddr_chk_pkg`:
  - state enum `chk_state_t`;
  - `PRBS_LOCKUP = 5'b11111`;
  - function `prbs5_next(s)` implementing the team PRBS.
- Sub-module `prbs5_pair_pred`: combinational; takes `r`, outputs `p0`, `p1` and the 2-step-advanced register. It is shared with the sibling generator stage.
- Top level holds the FSM, counters and output registers.

## Test plan
- **Reset:** hold `rst_n`=0 with random inputs → `state`=0, `locked`=0, `err_cnt`=0, `err_pulse`=0.
- **Clean lock:** drive the team PRBS from seed 0 (sequence 1,1,1,0,0,…), two bits per cycle, `in_valid`=1.
  - `state` sequence over edges 1..7: 0,0,1,1,1,1,2.
  - `locked`=1 from edge 7.
  - `err_cnt` stays 0 for 100 cycles.
- **Single flip:** after lock, invert one `bit_fall`.
  - One-cycle `err_pulse`; `err_cnt`=1; `locked` stays 1.
  - The next cycle is clean (no error propagation).
- **Lockup/garbage:** constant 1s on both bits for 50 cycles → never leaves VERIFY, `locked`=0. Constant 0s behave the same.
- **Loss of lock:** after lock, invert both bits for 4 cycles.
  - `err_cnt`=8.
  - `locked` falls on the 4th bad edge.
  - A clean stream then relocks within 7 valid cycles.
- **Saturation and clear:**
  - Preload to 254 via errors, then one 2-bit error → `err_cnt`=255; further errors hold 255.
  - `clr_err` coincident with an error → `err_cnt`=0.
  - `in_valid`=0 gaps mid-stream cause no errors.

Source files
------------

// File: rtl/ddr_chk_pkg.sv
// Shared types and PRBS helpers for the DDR capture checker and generator.
package ddr_chk_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_t;

    localparam logic [4:0] PRBS_LOCKUP = 5'b11111;

    // One step of the 5-bit XNOR PRBS; the new bit enters at the LSB.
    function automatic logic [4:0] prbs5_next(input logic [4:0] s);
        return {s[3:0], ~(s[4] ^ s[2])};
    endfunction

endpackage

// File: rtl/prbs5_pair_pred.sv
// Predicts the next two stream bits and the register advanced by two steps.
module prbs5_pair_pred
    import ddr_chk_pkg::*;
(
    input  logic [4:0] r,
    output logic       p0,
    output logic       p1,
    output logic [4:0] r_adv_c
);

    logic [4:0] step1;
    logic [4:0] step2;

    // Two PRBS steps; the LSB of each step is the predicted bit.
    always_comb begin
        step1   = prbs5_next(r);
        step2   = prbs5_next(step1);
        p0      = step1[0];
        p1      = step2[0];
        r_adv_c = step2;
    end

endmodule

// File: rtl/ddr_prbs_checker.sv
// Checks DDR rise/fall bit pairs against the team PRBS5; reports lock and errors.
module ddr_prbs_checker
    import ddr_chk_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 4,
    parameter int unsigned ERR_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             bit_rise,
    input  logic             bit_fall,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned FILL_W = 2;

    chk_state_t        st_q, st_d;
    logic [4:0]        r_q, r_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  bad_q, bad_d;
    logic [ERR_W-1:0]  err_d;
    logic              pulse_d;
    logic              locked_d;

    logic              p0, p1;
    logic [4:0]        r_adv_c;
    logic              m0, m1;
    logic [ERR_W:0]    err_sum;
    logic [ERR_W-1:0]  err_sat;

    prbs5_pair_pred u_pred (
        .r       (r_q),
        .p0      (p0),
        .p1      (p1),
        .r_adv_c (r_adv_c)
    );

    // Per-bit mismatch and saturating error accumulation.
    always_comb begin
        m0      = bit_rise ^ p0;
        m1      = bit_fall ^ p1;
        err_sum = {1'b0, err_cnt} + (ERR_W+1)'(m0) + (ERR_W+1)'(m1);
        err_sat = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
    end

    // State register and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_SEARCH;
            r_q       <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            bad_q     <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
        end else begin
            st_q      <= st_d;
            r_q       <= r_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            bad_q     <= bad_d;
            err_cnt   <= err_d;
            err_pulse <= pulse_d;
            locked    <= locked_d;
        end
    end

    // Next-state, counters and next output values.
    always_comb begin
        st_d    = st_q;
        r_d     = r_q;
        fill_d  = fill_q;
        match_d = match_q;
        bad_d   = bad_q;
        err_d   = err_cnt;
        pulse_d = 1'b0;

        if (in_valid) begin
            case (st_q)
                ST_SEARCH: begin
                    r_d = {r_q[2:0], bit_rise, bit_fall};
                    if (fill_q == FILL_W'(2)) begin
                        st_d    = ST_VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    r_d = {r_q[2:0], bit_rise, bit_fall};
                    // The lockup state is a valid fixed point of the XNOR PRBS, so it never counts.
                    if (!m0 && !m1 && (r_q != PRBS_LOCKUP)) begin
                        if (match_q == CNT_W'(LOCK_COUNT - 1)) begin
                            st_d    = ST_LOCKED;
                            match_d = '0;
                            bad_d   = '0;
                        end else begin
                            match_d = match_q + CNT_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on predictions so corrupted data cannot poison the reference.
                    r_d     = r_adv_c;
                    pulse_d = m0 | m1;
                    err_d   = err_sat;
                    if (m0 || m1) begin
                        if (bad_q == CNT_W'(UNLOCK_COUNT - 1)) begin
                            st_d   = ST_SEARCH;
                            fill_d = '0;
                            bad_d  = '0;
                        end else begin
                            bad_d = bad_q + CNT_W'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: begin
                    st_d   = ST_SEARCH;
                    fill_d = '0;
                end
            endcase
        end

        if (clr_err) begin
            err_d = '0;
        end

        locked_d = (st_d == ST_LOCKED);
    end

    assign state = st_q;

endmodule

// File: tb/tb_ddr_prbs_checker.sv
// Directed scoreboard bench for ddr_prbs_checker.
module tb_ddr_prbs_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       bit_rise;
    logic       bit_fall;
    logic       clr_err;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic [1:0] state;

    typedef struct {
        logic [1:0] st;
        logic       lk;
        logic       ep;
        logic [7:0] ec;
        string      tag;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [4:0] g = 5'd0;

    ddr_prbs_checker #(
        .LOCK_COUNT   (4),
        .UNLOCK_COUNT (4),
        .ERR_W        (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .bit_rise  (bit_rise),
        .bit_fall  (bit_fall),
        .clr_err   (clr_err),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input string tag, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s [%s] @%0t: got %0d expected %0d", name, tag, $time, act, expv);
        end
    endtask

    // Monitor: every rising edge produces an output set, compared just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state",     e.tag, int'(state),     int'(e.st));
            chk("locked",    e.tag, int'(locked),    int'(e.lk));
            chk("err_pulse", e.tag, int'(err_pulse), int'(e.ep));
            chk("err_cnt",   e.tag, int'(err_cnt),   int'(e.ec));
        end
    end

    // Drive one cycle on the falling edge and queue the values expected after the next rising edge.
    task automatic step(input logic rst, input logic vld, input logic br, input logic bf,
                        input logic clr, input logic [1:0] st, input logic lk,
                        input logic ep, input logic [7:0] ec, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n    = rst;
        in_valid = vld;
        bit_rise = br;
        bit_fall = bf;
        clr_err  = clr;
        e.st = st; e.lk = lk; e.ep = ep; e.ec = ec; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Stimulus generator: two successive PRBS bits.
    task automatic next_pair(output logic b0, output logic b1);
        b0 = ~(g[4] ^ g[2]);
        g  = {g[3:0], b0};
        b1 = ~(g[4] ^ g[2]);
        g  = {g[3:0], b1};
    endtask

    // One valid PRBS cycle; inv[1] flips bit_rise, inv[0] flips bit_fall.
    task automatic gen(input logic [1:0] inv, input logic clr, input logic [1:0] st,
                       input logic lk, input logic ep, input logic [7:0] ec, input string tag);
        logic b0, b1;
        next_pair(b0, b1);
        step(1'b1, 1'b1, b0 ^ inv[1], b1 ^ inv[0], clr, st, lk, ep, ec, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] lock_seq [7];
        lock_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        rst_n = 1'b0; in_valid = 1'b0; bit_rise = 1'b0; bit_fall = 1'b0; clr_err = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 2'd0, 1'b0, 1'b0, 8'd0, "reset");

        // Clean lock from seed 0: lock on the 7th valid edge.
        for (int i = 0; i < 7; i++)
            gen(2'b00, 1'b0, lock_seq[i], (i == 6), 1'b0, 8'd0, "lock");
        for (int i = 0; i < 100; i++)
            gen(2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0, "clean100");

        // Single bit_fall flip: one pulse, count 1, still locked, next cycle clean.
        gen(2'b01, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1, "flip");
        for (int i = 0; i < 5; i++)
            gen(2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 8'd1, "after_flip");

        // in_valid gaps hold everything and raise no errors.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 2'd2, 1'b1, 1'b0, 8'd1, "gap");
            gen(2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 8'd1, "gap_data");
        end

        // Clear, then four double-bit errors drop lock with count 8.
        gen(2'b00, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0, "clr");
        gen(2'b11, 1'b0, 2'd2, 1'b1, 1'b1, 8'd2, "bad1");
        gen(2'b11, 1'b0, 2'd2, 1'b1, 1'b1, 8'd4, "bad2");
        gen(2'b11, 1'b0, 2'd2, 1'b1, 1'b1, 8'd6, "bad3");
        gen(2'b11, 1'b0, 2'd0, 1'b0, 1'b1, 8'd8, "bad4_unlock");
        for (int i = 0; i < 7; i++)
            gen(2'b00, 1'b0, lock_seq[i], (i == 6), 1'b0, 8'd8, "relock");

        // Saturation: climb to 254, then 2-bit error to 255 and hold.
        gen(2'b00, 1'b1, 2'd2, 1'b1, 1'b0, 8'd0, "clr2");
        for (int k = 1; k <= 127; k++) begin
            gen(2'b11, 1'b0, 2'd2, 1'b1, 1'b1, 8'(2 * k), "climb_err");
            gen(2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 8'(2 * k), "climb_ok");
        end
        gen(2'b11, 1'b0, 2'd2, 1'b1, 1'b1, 8'd255, "sat254p2");
        gen(2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 8'd255, "sat_ok");
        gen(2'b11, 1'b0, 2'd2, 1'b1, 1'b1, 8'd255, "sat_hold2");
        gen(2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 8'd255, "sat_ok2");
        gen(2'b10, 1'b0, 2'd2, 1'b1, 1'b1, 8'd255, "sat_hold1");
        gen(2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 8'd255, "sat_ok3");

        // Clear beats a coincident error.
        gen(2'b11, 1'b1, 2'd2, 1'b1, 1'b1, 8'd0, "clr_vs_err");
        gen(2'b00, 1'b0, 2'd2, 1'b1, 1'b0, 8'd0, "post_clr");
        gen(2'b10, 1'b0, 2'd2, 1'b1, 1'b1, 8'd1, "post_clr_err");

        // Asynchronous reset mid-operation, then constant 1s never lock.
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, "midop_rst");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, "midop_rst2");
        for (int i = 0; i < 50; i++)
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, (i < 2) ? 2'd0 : 2'd1, 1'b0, 1'b0, 8'd0, "ones");

        // Constant 0s never lock either.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0, "rst_zeros");
        for (int i = 0; i < 50; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (i < 2) ? 2'd0 : 2'd1, 1'b0, 1'b0, 8'd0, "zeros");

        // Drain the scoreboard with a bounded wait.
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 8'd0, "idle");
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
